// File: rtl/weight_loader.sv
// weight_loader: fills a bank of NUM_WGT weight registers from a
// valid/ready stream. Optional checksum output under WGT_LOADER_CHECKSUM_EN.
module weight_loader #(
    parameter int WGT_WIDTH = 8,
    parameter int NUM_WGT   = 50,
    parameter int IDX_W     = 6
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           load_start,
    input  logic                           wgt_clear,
    input  logic [WGT_WIDTH-1:0]           wgt_in,
    input  logic                           wgt_valid,
    output logic                           wgt_ready,
    output logic [NUM_WGT*WGT_WIDTH-1:0]   weights_flat,
    output logic [IDX_W-1:0]               wgt_count,
    output logic                           load_busy,
`ifdef WGT_LOADER_CHECKSUM_EN
    output logic                           load_done,
    output logic [WGT_WIDTH+IDX_W-1:0]     wgt_checksum
`else
    output logic                           load_done
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WGT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [NUM_WGT-1:0][WGT_WIDTH-1:0] bank;

    logic accept;
    logic last_beat;
    logic start_idle;
    logic start_load;
    logic clear_en;

    assign accept     = wgt_valid & wgt_ready;
    assign last_beat  = accept & (wgt_count == LAST_IDX);
    assign start_idle = (state == S_IDLE) & load_start;
    assign start_load = (state == S_LOAD) & load_start;
    assign clear_en   = (state == S_IDLE) & wgt_clear & ~load_start;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (load_start) state_nxt = S_LOAD;
            S_LOAD: if (last_beat)  state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state; ready never looks at valid or data
    always_comb begin
        wgt_ready = 1'b0;
        load_busy = 1'b0;
        load_done = 1'b0;
        unique case (state)
            S_LOAD: begin
                load_busy = 1'b1;
                wgt_ready = ~load_start;
            end
            S_DONE:  load_done = 1'b1;
            default: ;
        endcase
    end

    // Write index: restarts on any start, steps per accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wgt_count <= '0;
        end else if (start_idle || start_load) begin
            wgt_count <= '0;
        end else if (accept) begin
            wgt_count <= last_beat ? '0 : wgt_count + 1'b1;
        end
    end

    // Weight bank: clear in IDLE, one entry written per accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank <= '0;
        end else if (clear_en) begin
            bank <= '0;
        end else begin
            for (int i = 0; i < NUM_WGT; i++) begin
                if (accept && (wgt_count == IDX_W'(i))) bank[i] <= wgt_in;
            end
        end
    end

    assign weights_flat = bank;

`ifdef WGT_LOADER_CHECKSUM_EN
    // Running sum of the beats accepted in the current sequence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wgt_checksum <= '0;
        end else if (start_idle || start_load || clear_en) begin
            wgt_checksum <= '0;
        end else if (accept) begin
            wgt_checksum <= wgt_checksum + (WGT_WIDTH+IDX_W)'(wgt_in);
        end
    end
`endif

endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: directed and randomized checks of weight_loader
// against a behavioural bank/sequence model.
module tb_weight_loader;

    localparam int W  = 8;
    localparam int N  = 50;
    localparam int IW = 6;
    localparam int FW = N * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_start;
    logic          wgt_clear;
    logic [W-1:0]  wgt_in;
    logic          wgt_valid;
    logic          wgt_ready;
    logic [FW-1:0] weights_flat;
    logic [IW-1:0] wgt_count;
    logic          load_busy;
    logic          load_done;
`ifdef WGT_LOADER_CHECKSUM_EN
    logic [W+IW-1:0] wgt_checksum;
`endif

    weight_loader #(.WGT_WIDTH(W), .NUM_WGT(N), .IDX_W(IW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_start   (load_start),
        .wgt_clear    (wgt_clear),
        .wgt_in       (wgt_in),
        .wgt_valid    (wgt_valid),
        .wgt_ready    (wgt_ready),
        .weights_flat (weights_flat),
        .wgt_count    (wgt_count),
        .load_busy    (load_busy),
`ifdef WGT_LOADER_CHECKSUM_EN
        .load_done    (load_done),
        .wgt_checksum (wgt_checksum)
`else
        .load_done    (load_done)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: bank contents, write position, phase, running sum
    int m_bank [N];
    int m_pos;
    int m_phase;   // 0 idle, 1 loading, 2 done pulse
    int m_sum;
    int done_seen;

    task automatic chk(input string tag, input logic [FW-1:0] obs,
                       input logic [FW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] m_flat();
        logic [FW-1:0] f = '0;
        for (int i = 0; i < N; i++) f[i*W +: W] = W'(m_bank[i]);
        return f;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) m_bank[i] = 0;
        m_pos = 0;
        m_phase = 0;
        m_sum = 0;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".bank"}, weights_flat, m_flat());
        chk({tag, ".count"}, FW'(wgt_count), FW'(m_pos));
        chk({tag, ".busy"}, FW'(load_busy), FW'(m_phase == 1));
        chk({tag, ".done"}, FW'(load_done), FW'(m_phase == 2));
`ifdef WGT_LOADER_CHECKSUM_EN
        chk({tag, ".sum"}, FW'(wgt_checksum), FW'(m_sum));
`endif
    endtask

    // One clock cycle: apply inputs, check ready, step model, check state
    task automatic cycle(input logic st, input logic cl, input logic vd,
                         input logic [W-1:0] d);
        logic exp_rdy;
        load_start = st;
        wgt_clear  = cl;
        wgt_valid  = vd;
        wgt_in     = d;
        exp_rdy    = (m_phase == 1) && !st;
        #1;
        chk("ready", FW'(wgt_ready), FW'(exp_rdy));
        @(posedge clk);
        #1;
        case (m_phase)
            0: begin
                if (st) begin
                    m_phase = 1; m_pos = 0; m_sum = 0;
                end else if (cl) begin
                    for (int i = 0; i < N; i++) m_bank[i] = 0;
                    m_sum = 0;
                end
            end
            1: begin
                if (st) begin
                    m_pos = 0; m_sum = 0;
                end else if (vd) begin
                    m_bank[m_pos] = d;
                    m_sum += d;
                    if (m_pos == N - 1) begin
                        m_pos = 0; m_phase = 2;
                    end else begin
                        m_pos++;
                    end
                end
            end
            default: m_phase = 0;
        endcase
        chk_outputs("cyc");
        if (load_done) done_seen++;
    endtask

    int t0, t1, n;
    logic [W-1:0] d;

    initial begin
        m_reset();
        rst_n = 1'b0;
        load_start = 0; wgt_clear = 0; wgt_valid = 0; wgt_in = '0;
        #12;
        chk_outputs("reset");
        chk("reset.ready", FW'(wgt_ready), '0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        repeat (2) cycle(0, 0, 0, 8'h00);

        // Back-to-back load of i+1
        done_seen = 0;
        cycle(1, 0, 0, 8'h00);
        t0 = 0;
        for (int i = 0; i < N; i++) begin
            cycle(0, 0, 1, W'(i + 1));
            t0++;
        end
        chk("b2b.done_after_last", FW'(load_done), FW'(1));
        for (int i = 0; i < N; i++)
            chk("b2b.entry", FW'(weights_flat[i*W +: W]), FW'(i + 1));
`ifdef WGT_LOADER_CHECKSUM_EN
        chk("b2b.sum1275", FW'(wgt_checksum), FW'(1275));
`endif
        cycle(0, 0, 0, 8'h00);
        chk("b2b.done_once", FW'(done_seen), FW'(1));

        // Clear then same load with valid every other cycle
        cycle(0, 1, 0, 8'h00);
        chk("clear.bank", weights_flat, '0);
        cycle(1, 0, 0, 8'h00);
        t1 = 0; n = 0;
        while (n < N) begin
            cycle(0, 0, (t1 % 2) == 0, W'(n + 1));
            if ((t1 % 2) == 0) n++;
            t1++;
        end
        chk("toggle.done", FW'(load_done), FW'(1));
        chk("toggle.delay", FW'(t1 - t0), FW'(N - 1));
        cycle(0, 0, 0, 8'h00);

        // Restart mid-load with clear attempts during LOAD
        done_seen = 0;
        cycle(1, 0, 0, 8'h00);
        for (int i = 0; i < 20; i++) cycle(0, i == 5, 1, 8'hAA);
        cycle(1, 1, 1, 8'hEE);
        chk("restart.count", FW'(wgt_count), '0);
        for (int i = 0; i < N; i++) cycle(0, i == 7, 1, 8'h55);
        cycle(0, 0, 0, 8'h00);
        cycle(0, 0, 0, 8'h00);
        chk("restart.done_once", FW'(done_seen), FW'(1));
        for (int i = 0; i < N; i++)
            chk("restart.entry", FW'(weights_flat[i*W +: W]), FW'(8'h55));

        // Start and clear together in IDLE: start wins
        cycle(1, 1, 0, 8'h00);
        chk("startwins.bank0", FW'(weights_flat[0 +: W]), FW'(8'h55));
        for (int i = 0; i < N + 2; i++) cycle(0, 0, 1, W'($urandom));

        // Randomized loads
        for (int s = 0; s < 4; s++) begin
            int budget;
            done_seen = 0;
            budget = 0;
            cycle(1, 0, 0, 8'h00);
            while (done_seen == 0 && budget < 2000) begin
                cycle(($urandom_range(0, 63) == 0), $urandom_range(0, 1),
                      ($urandom_range(0, 9) < 7), W'($urandom));
                budget++;
            end
            chk("rand.finished", FW'(done_seen), FW'(1));
            repeat ($urandom_range(0, 3))
                cycle(0, 0, $urandom_range(0, 1), W'($urandom));
        end

        // Asynchronous reset after 30 beats
        done_seen = 0;
        cycle(1, 0, 0, 8'h00);
        for (int i = 0; i < 30; i++) cycle(0, 0, 1, W'(i + 100));
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        chk_outputs("async_rst");
        chk("async_rst.ready", FW'(wgt_ready), '0);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 8'h11);
        chk("async_rst.no_done", FW'(done_seen), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
